// File: rtl/sc_displaytimer_counter_mod.sv
// Prescaled modulo up/down game timer with load, pause and expiry flag.
// Optional BCD readout enabled by defining SC_DISPLAYTIMER_COUNTER_BCD_EN.
module sc_displaytimer_counter_mod #(
   parameter int DATAWIDTH      = 8,
   parameter int MAXCOUNT       = 99,
   parameter int INIT_VALUE     = 99,
   parameter int PRESCALE       = 50000000,
   parameter int PRESCALE_WIDTH = 26
) (
   input  logic                 SC_DISPLAYTIMER_COUNTER_CLOCK_50,
   input  logic                 SC_DISPLAYTIMER_COUNTER_RESET_InHigh,
   input  logic                 SC_DISPLAYTIMER_COUNTER_start_InLow,
   input  logic                 SC_DISPLAYTIMER_COUNTER_pause_InLow,
   input  logic                 SC_DISPLAYTIMER_COUNTER_load_InLow,
   input  logic [DATAWIDTH-1:0] SC_DISPLAYTIMER_COUNTER_load_InBUS,
   input  logic                 SC_DISPLAYTIMER_COUNTER_updown_In,
   output logic [DATAWIDTH-1:0] SC_DISPLAYTIMER_COUNTER_data_OutBUS,
   output logic                 SC_DISPLAYTIMER_COUNTER_tc_Out,
   output logic                 SC_DISPLAYTIMER_COUNTER_expired_Out,
`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
   output logic [11:0]          SC_DISPLAYTIMER_COUNTER_bcd_OutBUS,
`endif
   output logic                 SC_DISPLAYTIMER_COUNTER_running_Out
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

   localparam logic [DATAWIDTH-1:0]      MAX_C      = DATAWIDTH'(MAXCOUNT);
   localparam logic [DATAWIDTH-1:0]      INIT_C     = DATAWIDTH'(INIT_VALUE);
   localparam logic [PRESCALE_WIDTH-1:0] PRESC_LAST = PRESCALE_WIDTH'(PRESCALE - 1);

   state_t                    state_q, state_d;
   logic [DATAWIDTH-1:0]      count_q, count_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic                      tc_q, tc_d;
   logic                      expired_q, running_q;
   logic [DATAWIDTH-1:0]      term;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      tc_d    = 1'b0;
      term    = SC_DISPLAYTIMER_COUNTER_updown_In ? MAX_C : '0;
      if (!SC_DISPLAYTIMER_COUNTER_load_InLow) begin
         count_d = (SC_DISPLAYTIMER_COUNTER_load_InBUS > MAX_C) ? MAX_C
                                                                : SC_DISPLAYTIMER_COUNTER_load_InBUS;
         presc_d = '0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!SC_DISPLAYTIMER_COUNTER_start_InLow) begin
                  state_d = RUN;
                  presc_d = '0;
               end
            end
            // Releasing pause counts the same edge, so the step is delayed only by the paused cycles.
            RUN, PAUSE: begin
               if (!SC_DISPLAYTIMER_COUNTER_pause_InLow) begin
                  state_d = PAUSE;
               end else begin
                  state_d = RUN;
                  if (presc_q == PRESC_LAST) begin
                     presc_d = '0;
                     if (count_q != term)
                        count_d = SC_DISPLAYTIMER_COUNTER_updown_In ? count_q + 1'b1
                                                                    : count_q - 1'b1;
                     if (count_d == term) begin
                        state_d = EXPIRED;
                        tc_d    = 1'b1;
                     end
                  end else begin
                     presc_d = presc_q + 1'b1;
                  end
               end
            end
            EXPIRED: begin
               if (!SC_DISPLAYTIMER_COUNTER_start_InLow) begin
                  count_d = INIT_C;
                  presc_d = '0;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge SC_DISPLAYTIMER_COUNTER_CLOCK_50 or posedge SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
      if (SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
         state_q   <= IDLE;
         count_q   <= INIT_C;
         presc_q   <= '0;
         tc_q      <= 1'b0;
         expired_q <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         tc_q      <= tc_d;
         expired_q <= (state_d == EXPIRED);
         running_q <= (state_d == RUN);
      end
   end

   assign SC_DISPLAYTIMER_COUNTER_data_OutBUS = count_q;
   assign SC_DISPLAYTIMER_COUNTER_tc_Out      = tc_q;
   assign SC_DISPLAYTIMER_COUNTER_expired_Out = expired_q;
   assign SC_DISPLAYTIMER_COUNTER_running_Out = running_q;

`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
   function automatic logic [11:0] to_bcd(input logic [DATAWIDTH-1:0] bin);
      int v;
      v = int'(bin);
      if (v > 999) v = 999;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   logic [11:0] bcd_q;

   // Converts the registered count, so the BCD view trails data_OutBUS by one clock.
   always_ff @(posedge SC_DISPLAYTIMER_COUNTER_CLOCK_50 or posedge SC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
      if (SC_DISPLAYTIMER_COUNTER_RESET_InHigh) bcd_q <= to_bcd(INIT_C);
      else                                      bcd_q <= to_bcd(count_q);
   end

   assign SC_DISPLAYTIMER_COUNTER_bcd_OutBUS = bcd_q;
`endif

endmodule

// File: tb/tb_sc_displaytimer_counter_mod.sv
// Bench for sc_displaytimer_counter_mod: directed vector table, async-reset sequence,
// then random stimulus against a cycle-level behavioural timer model.
module tb_sc_displaytimer_counter_mod;

   localparam int DW = 8, MAXC = 9, INITV = 3, PS = 4, PSW = 3;

   logic clk = 1'b0, rst = 1'b1;
   logic st_n = 1'b1, pa_n = 1'b1, ld_n = 1'b1, ud = 1'b0;
   logic [DW-1:0] ld = '0;
   logic [DW-1:0] data;
   logic tc, expd, run;
`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
   logic [11:0] bcd;
`endif

   always #5 clk = ~clk;

   sc_displaytimer_counter_mod #(
      .DATAWIDTH(DW), .MAXCOUNT(MAXC), .INIT_VALUE(INITV), .PRESCALE(PS), .PRESCALE_WIDTH(PSW)
   ) dut (
      .SC_DISPLAYTIMER_COUNTER_CLOCK_50    (clk),
      .SC_DISPLAYTIMER_COUNTER_RESET_InHigh(rst),
      .SC_DISPLAYTIMER_COUNTER_start_InLow (st_n),
      .SC_DISPLAYTIMER_COUNTER_pause_InLow (pa_n),
      .SC_DISPLAYTIMER_COUNTER_load_InLow  (ld_n),
      .SC_DISPLAYTIMER_COUNTER_load_InBUS  (ld),
      .SC_DISPLAYTIMER_COUNTER_updown_In   (ud),
      .SC_DISPLAYTIMER_COUNTER_data_OutBUS (data),
      .SC_DISPLAYTIMER_COUNTER_tc_Out      (tc),
      .SC_DISPLAYTIMER_COUNTER_expired_Out (expd),
`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
      .SC_DISPLAYTIMER_COUNTER_bcd_OutBUS  (bcd),
`endif
      .SC_DISPLAYTIMER_COUNTER_running_Out (run)
   );

   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input int exp_data, input bit exp_tc,
                        input bit exp_exp, input bit exp_run);
      n_vec++;
      if (int'(data) != exp_data || tc !== exp_tc || expd !== exp_exp || run !== exp_run) begin
         n_err++;
         $display("FAIL %s: got data=%0d tc=%b exp=%b run=%b, want data=%0d tc=%b exp=%b run=%b",
                  name, data, tc, expd, run, exp_data, exp_tc, exp_exp, exp_run);
      end
   endtask

`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
   function automatic logic [11:0] dec3(input int v);
      if (v > 999) v = 999;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check_bcd(input string name, input logic [11:0] want);
      n_vec++;
      if (bcd !== want) begin
         n_err++;
         $display("FAIL %s: got bcd=%h want %h", name, bcd, want);
      end
   endtask
`endif

   // Directed vectors: apply inputs, advance ncyc clocks, then compare.
   typedef struct {
      logic st_n, pa_n, ld_n;
      logic [DW-1:0] ld;
      logic ud;
      int ncyc;
      int e_data;
      bit e_tc, e_exp, e_run;
   } vec_t;

   function automatic vec_t mk(input logic s, input logic p, input logic l, input int lv,
                               input logic u, input int n, input int d,
                               input bit t, input bit e, input bit r);
      vec_t v;
      v.st_n = s; v.pa_n = p; v.ld_n = l; v.ld = DW'(lv); v.ud = u; v.ncyc = n;
      v.e_data = d; v.e_tc = t; v.e_exp = e; v.e_run = r;
      return v;
   endfunction

   // Behavioural model: mode 0 idle, 1 counting, 2 paused, 3 expired; ph = clocks into current step.
   int m_mode, m_cnt, m_ph, m_prev;
   bit m_tc;

   task automatic model_reset();
      m_mode = 0; m_cnt = INITV; m_ph = 0; m_tc = 0; m_prev = INITV;
   endtask

   task automatic model_step();
      int goal;
      m_prev = m_cnt;
      m_tc = 0;
      if (!ld_n) begin
         m_cnt = (int'(ld) > MAXC) ? MAXC : int'(ld);
         m_ph = 0; m_mode = 0;
      end else if (m_mode == 0) begin
         if (!st_n) begin m_mode = 1; m_ph = 0; end
      end else if (m_mode == 3) begin
         if (!st_n) begin m_mode = 1; m_ph = 0; m_cnt = INITV; end
      end else if (!pa_n) begin
         m_mode = 2;
      end else begin
         m_mode = 1;
         m_ph++;
         if (m_ph == PS) begin
            m_ph = 0;
            goal = ud ? MAXC : 0;
            if (m_cnt < goal) m_cnt++;
            else if (m_cnt > goal) m_cnt--;
            if (m_cnt == goal) begin m_mode = 3; m_tc = 1; end
         end
      end
   endtask

   vec_t tbl[31];

   initial begin
      tbl[0]  = mk(1,1,1, 0,0,1, 3,0,0,0);   // idle after reset
      tbl[1]  = mk(0,1,1, 0,0,1, 3,0,0,1);   // start
      tbl[2]  = mk(1,1,1, 0,0,3, 3,0,0,1);
      tbl[3]  = mk(1,1,1, 0,0,1, 2,0,0,1);   // first step after 4 clocks
      tbl[4]  = mk(1,1,1, 0,0,4, 1,0,0,1);
      tbl[5]  = mk(1,1,1, 0,0,4, 0,1,1,0);   // terminal 0
      tbl[6]  = mk(1,1,1, 0,0,1, 0,0,1,0);   // tc single pulse
      tbl[7]  = mk(1,1,1, 0,0,3, 0,0,1,0);
      tbl[8]  = mk(1,1,0, 7,1,1, 7,0,0,0);   // load 7, up
      tbl[9]  = mk(0,1,1, 0,1,1, 7,0,0,1);
      tbl[10] = mk(1,1,1, 0,1,4, 8,0,0,1);
      tbl[11] = mk(1,1,1, 0,1,4, 9,1,1,0);   // terminal MAXCOUNT
      tbl[12] = mk(1,1,1, 0,1,1, 9,0,1,0);
      tbl[13] = mk(1,1,1, 0,1,8, 9,0,1,0);   // no wrap
      tbl[14] = mk(1,1,0, 5,0,1, 5,0,0,0);
      tbl[15] = mk(0,1,1, 0,0,1, 5,0,0,1);
      tbl[16] = mk(1,1,1, 0,0,2, 5,0,0,1);
      tbl[17] = mk(1,0,1, 0,0,2, 5,0,0,0);   // paused 2 clocks
      tbl[18] = mk(1,1,1, 0,0,1, 5,0,0,1);
      tbl[19] = mk(1,1,1, 0,0,1, 4,0,0,1);   // step 4+2 clocks after start
      tbl[20] = mk(1,1,1, 0,0,2, 4,0,0,1);
      tbl[21] = mk(1,1,0,15,0,1, 9,0,0,0);   // clamped load while running
      tbl[22] = mk(1,1,1, 0,0,5, 9,0,0,0);
      tbl[23] = mk(1,1,0, 1,0,1, 1,0,0,0);
      tbl[24] = mk(0,1,1, 0,0,1, 1,0,0,1);
      tbl[25] = mk(1,1,1, 0,0,4, 0,1,1,0);
      tbl[26] = mk(0,1,1, 0,0,1, 3,0,0,1);   // restart from expired
      tbl[27] = mk(1,1,1, 0,0,4, 2,0,0,1);
      tbl[28] = mk(1,1,0, 0,0,1, 0,0,0,0);
      tbl[29] = mk(0,1,1, 0,0,1, 0,0,0,1);
      tbl[30] = mk(1,1,1, 0,0,4, 0,1,1,0);   // started at terminal

      repeat (3) @(posedge clk);
      #1;
      check("reset_state", INITV, 0, 0, 0);
`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
      check_bcd("reset_bcd", 12'h003);
`endif
      rst = 1'b0;

      for (int i = 0; i < 31; i++) begin
         st_n = tbl[i].st_n; pa_n = tbl[i].pa_n; ld_n = tbl[i].ld_n;
         ld = tbl[i].ld; ud = tbl[i].ud;
         repeat (tbl[i].ncyc) @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_tc, tbl[i].e_exp, tbl[i].e_run);
      end

`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
      ld_n = 1'b0; ld = 8'd9; st_n = 1'b1;
      @(posedge clk); #1;
      ld_n = 1'b1;
      check_bcd("bcd_lag", 12'h000);
      @(posedge clk); #1;
      check_bcd("bcd_9", 12'h009);
`endif

      // Async reset in the middle of a count step.
      ld_n = 1'b0; ld = 8'd7; ud = 1'b0;
      @(posedge clk); #1;
      ld_n = 1'b1; st_n = 1'b0;
      @(posedge clk); #1;
      st_n = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset", INITV, 0, 0, 0);
      @(posedge clk); #1;
      check("reset_held", INITV, 0, 0, 0);

      // Random stimulus against the model.
      model_reset();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         st_n = ($urandom_range(0, 7) != 0);
         pa_n = ($urandom_range(0, 5) != 0);
         ld_n = ($urandom_range(0, 39) != 0);
         ld   = DW'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) ud = ~ud;
         @(posedge clk); #1;
         model_step();
         check($sformatf("rand%0d", c), m_cnt, m_tc, m_mode == 3, m_mode == 1);
`ifdef SC_DISPLAYTIMER_COUNTER_BCD_EN
         if (c > 0) check_bcd($sformatf("rand_bcd%0d", c), dec3(m_prev));
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
